// File: rtl/sa_3x3.sv
// 3x3 weight-stationary systolic array of 8-bit MAC PEs, plus the fadd8 helper adder.
// Weights shift down from the top, activations move right, partial sums move down.
// Optional build macro SA_SATURATE_EN: saturating product and accumulate (fadd8 always wraps).

// Combinational 8-bit wrapping adder.
module fadd8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] out
);

  // Modulo-256 sum; carry is intentionally dropped.
  assign out = a + b;

endmodule

module sa_3x3 #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          weight_load,
  input  logic [DW-1:0] w_in1,
  input  logic [DW-1:0] w_in2,
  input  logic [DW-1:0] w_in3,
  input  logic [DW-1:0] act_in1,
  input  logic [DW-1:0] act_in2,
  input  logic [DW-1:0] act_in3,
  input  logic [DW-1:0] psum_in1,
  input  logic [DW-1:0] psum_in2,
  input  logic [DW-1:0] psum_in3,
  output logic [DW-1:0] psum_out1,
  output logic [DW-1:0] psum_out2,
  output logic [DW-1:0] psum_out3
);

  // Edge-of-array inputs gathered into arrays so the PE grid can be generated.
  logic [DW-1:0] w_top    [3];
  logic [DW-1:0] act_left [3];
  logic [DW-1:0] psum_top [3];

  // Inter-PE links. Row 3 weights and column 3 activations feed nothing onward.
  logic [DW-1:0] w_link    [2][3];
  logic [DW-1:0] act_link  [3][2];
  logic [DW-1:0] psum_link [3][3];

  assign w_top[0]    = w_in1;
  assign w_top[1]    = w_in2;
  assign w_top[2]    = w_in3;
  assign act_left[0] = act_in1;
  assign act_left[1] = act_in2;
  assign act_left[2] = act_in3;
  assign psum_top[0] = psum_in1;
  assign psum_top[1] = psum_in2;
  assign psum_top[2] = psum_in3;

  for (genvar i = 0; i < 3; i++) begin : g_row
    for (genvar j = 0; j < 3; j++) begin : g_col
      logic [DW-1:0] w_src;
      logic [DW-1:0] act_src;
      logic [DW-1:0] psum_src;
      logic [DW-1:0] prod;
      logic [DW-1:0] sum;
      logic [DW-1:0] w_q;
      logic [DW-1:0] psum_q;

      if (i == 0) begin : g_top
        assign w_src    = w_top[j];
        assign psum_src = psum_top[j];
      end else begin : g_below
        assign w_src    = w_link[i-1][j];
        assign psum_src = psum_link[i-1][j];
      end

      if (j == 0) begin : g_left
        assign act_src = act_left[i];
      end else begin : g_right
        assign act_src = act_link[i][j-1];
      end

`ifdef SA_SATURATE_EN
      logic [2*DW-1:0] prod_full;
      logic [DW:0]     sum_full;

      // Clamp to all-ones whenever the product or the accumulate overflows DW bits.
      assign prod_full = (2*DW)'(w_q) * (2*DW)'(act_src);
      assign prod      = (|prod_full[2*DW-1:DW]) ? '1 : prod_full[DW-1:0];
      assign sum_full  = {1'b0, psum_src} + {1'b0, prod};
      assign sum       = sum_full[DW] ? '1 : sum_full[DW-1:0];
`else
      // Product truncated to DW bits; accumulate wraps.
      assign prod = w_q * act_src;

      fadd8 u_acc (
        .a   (psum_src),
        .b   (prod),
        .out (sum)
      );
`endif

      // Weight shift-in and psum accumulate; rst beats clear beats normal update.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          w_q    <= '0;
          psum_q <= '0;
        end else begin
          if (weight_load) begin
            w_q <= w_src;
          end
          if (clear) begin
            psum_q <= '0;
          end else begin
            psum_q <= sum;
          end
        end
      end

      // Activation forwarding register, only where a right-hand neighbour consumes it.
      if (j < 2) begin : g_act_fwd
        logic [DW-1:0] act_q;

        // Pass the activation one PE to the right each cycle.
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            act_q <= '0;
          end else if (clear) begin
            act_q <= '0;
          end else begin
            act_q <= act_src;
          end
        end

        assign act_link[i][j] = act_q;
      end

      if (i < 2) begin : g_w_fwd
        assign w_link[i][j] = w_q;
      end

      assign psum_link[i][j] = psum_q;
    end
  end

  assign psum_out1 = psum_link[2][0];
  assign psum_out2 = psum_link[2][1];
  assign psum_out3 = psum_link[2][2];

endmodule

// File: tb/tb_sa_3x3.sv
// Self-checking bench for sa_3x3: directed matmul, psum injection, clear, overflow,
// mid-run reset and randomized streams against a matrix-level reference model.
module tb_sa_3x3;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       weight_load;
  logic [7:0] w_in1, w_in2, w_in3;
  logic [7:0] act_in1, act_in2, act_in3;
  logic [7:0] psum_in1, psum_in2, psum_in3;
  logic [7:0] psum_out1, psum_out2, psum_out3;
  logic [7:0] fa_a, fa_b, fa_o;
  logic [7:0] sum12, sum_all;

  int checks = 0;
  int errors = 0;

`ifdef SA_SATURATE_EN
  localparam logic [7:0] OvfExp = 8'd255;
`else
  localparam logic [7:0] OvfExp = 8'd0;
`endif

  // Reference state: weight matrix as seen by the array (row 0 = top), vector stream.
  logic [7:0] wm   [3][3];
  logic [7:0] lw   [3][3];
  logic [7:0] a_v  [32][3];
  logic [7:0] p_v  [32][3];
  logic [7:0] cap  [32][3];
  logic [7:0] cap_sum [32];
  int         nv;

  sa_3x3 #(.DW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .weight_load (weight_load),
    .w_in1       (w_in1),
    .w_in2       (w_in2),
    .w_in3       (w_in3),
    .act_in1     (act_in1),
    .act_in2     (act_in2),
    .act_in3     (act_in3),
    .psum_in1    (psum_in1),
    .psum_in2    (psum_in2),
    .psum_in3    (psum_in3),
    .psum_out1   (psum_out1),
    .psum_out2   (psum_out2),
    .psum_out3   (psum_out3)
  );

  fadd8 u_fa (.a(fa_a), .b(fa_b), .out(fa_o));
  fadd8 u_c1 (.a(psum_out1), .b(psum_out2), .out(sum12));
  fadd8 u_c2 (.a(sum12), .b(psum_out3), .out(sum_all));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] av(int k, int i);
    if (k < 0 || k >= nv) return 8'd0;
    return a_v[k][i];
  endfunction

  function automatic logic [7:0] pv(int k, int j);
    if (k < 0 || k >= nv) return 8'd0;
    return p_v[k][j];
  endfunction

  // Column j result for vector k: psum_in + sum_i W(i,j)*a_i, in the chosen arithmetic.
  function automatic logic [7:0] expv(int k, int j);
    int s;
    int pr;
    if (k < 0 || k >= nv) return 8'd0;
    s = int'(p_v[k][j]);
    for (int i = 0; i < 3; i++) begin
      pr = int'(wm[i][j]) * int'(a_v[k][i]);
`ifdef SA_SATURATE_EN
      if (pr > 255) pr = 255;
      s = s + pr;
      if (s > 255) s = 255;
`else
      s = (s + pr) % 256;
`endif
    end
    return 8'(s);
  endfunction

  // Shift lw[0], lw[1], lw[2] in; the last triple ends up in the top row.
  task automatic load_weights(input bit clr);
    for (int c = 0; c < 3; c++) begin
      w_in1 = lw[c][0];
      w_in2 = lw[c][1];
      w_in3 = lw[c][2];
      weight_load = 1'b1;
      clear = clr;
      @(posedge clk);
      #1;
    end
    weight_load = 1'b0;
    clear = 1'b0;
    for (int r = 0; r < 3; r++)
      for (int j = 0; j < 3; j++) wm[r][j] = lw[2-r][j];
  endtask

  // Feed nv skewed vectors and check every output after every edge until drained.
  task automatic run_stream(input string tag);
    logic [7:0] e0, e1, e2;
    for (int t = 1; t <= nv + 5; t++) begin
      act_in1  = av(t-1, 0);
      act_in2  = av(t-2, 1);
      act_in3  = av(t-3, 2);
      psum_in1 = pv(t-1, 0);
      psum_in2 = pv(t-2, 1);
      psum_in3 = pv(t-3, 2);
      @(posedge clk);
      #1;
      e0 = expv(t-3, 0);
      e1 = expv(t-4, 1);
      e2 = expv(t-5, 2);
      chk($sformatf("%s t%0d out1", tag, t), psum_out1, e0);
      chk($sformatf("%s t%0d out2", tag, t), psum_out2, e1);
      chk($sformatf("%s t%0d out3", tag, t), psum_out3, e2);
      chk($sformatf("%s t%0d fsum", tag, t), sum_all, 8'(e0 + e1 + e2));
      cap[t][0] = psum_out1;
      cap[t][1] = psum_out2;
      cap[t][2] = psum_out3;
      cap_sum[t] = sum_all;
    end
    {act_in1, act_in2, act_in3}    = '0;
    {psum_in1, psum_in2, psum_in3} = '0;
  endtask

  task automatic rand_vectors(input int n);
    nv = n;
    for (int k = 0; k < n; k++)
      for (int i = 0; i < 3; i++) begin
        a_v[k][i] = 8'($urandom_range(0, 255));
        p_v[k][i] = 8'($urandom_range(0, 255));
      end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " out1"}, psum_out1, 8'd0);
    chk({tag, " out2"}, psum_out2, 8'd0);
    chk({tag, " out3"}, psum_out3, 8'd0);
  endtask

  initial begin
    rst = 1'b0;
    clear = 1'b0;
    weight_load = 1'b0;
    {w_in1, w_in2, w_in3} = '0;
    {act_in1, act_in2, act_in3} = '0;
    {psum_in1, psum_in2, psum_in3} = '0;
    fa_a = '0;
    fa_b = '0;
    for (int r = 0; r < 3; r++)
      for (int j = 0; j < 3; j++) wm[r][j] = 8'd0;

    // Reset state.
    #12;
    check_zero("reset");
    rst = 1'b1;

    // Standalone fadd8, including a wrapping case.
    fa_a = 8'd200; fa_b = 8'd100; #1;
    chk("fadd8 wrap", fa_o, 8'd44);
    for (int n = 0; n < 4; n++) begin
      fa_a = 8'($urandom_range(0, 255));
      fa_b = 8'($urandom_range(0, 255));
      #1;
      chk("fadd8 rand", fa_o, 8'((int'(fa_a) + int'(fa_b)) % 256));
    end

    // Directed matmul.
    for (int c = 0; c < 3; c++)
      for (int j = 0; j < 3; j++) lw[c][j] = 8'(3 * c + j + 1);
    load_weights(1'b0);
    nv = 3;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 3; i++) begin
        a_v[k][i] = 8'(3 * i + k + 1);
        p_v[k][i] = 8'd0;
      end
    run_stream("mm");
    chk("mm first out1", cap[3][0], 8'd30);
    chk("mm first out2", cap[4][1], 8'd42);
    chk("mm e5 out1", cap[5][0], 8'd54);
    chk("mm e5 out2", cap[5][1], 8'd57);
    chk("mm e5 out3", cap[5][2], 8'd54);
    chk("mm e5 chain", cap_sum[5], 8'd165);
    chk("mm last out3", cap[7][2], 8'd90);

    // psum injection on column 1, first vector.
    p_v[0][0] = 8'd10;
    run_stream("inj");
    chk("inj first out1", cap[3][0], 8'd40);
    p_v[0][0] = 8'd0;

    // Random weights and random stream.
    for (int c = 0; c < 3; c++)
      for (int j = 0; j < 3; j++) lw[c][j] = 8'($urandom_range(0, 255));
    load_weights(1'b0);
    rand_vectors(8);
    run_stream("rnd");

    // Clear mid-stream, then replay the identical stream with retained weights.
    for (int t = 1; t <= 3; t++) begin
      act_in1  = av(t-1, 0);
      act_in2  = av(t-2, 1);
      act_in3  = av(t-3, 2);
      psum_in1 = pv(t-1, 0);
      psum_in2 = pv(t-2, 1);
      psum_in3 = pv(t-3, 2);
      @(posedge clk);
      #1;
    end
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    {act_in1, act_in2, act_in3} = '0;
    {psum_in1, psum_in2, psum_in3} = '0;
    check_zero("clear");
    run_stream("replay");

    // Clear held during weight load: weights shift, pipelines zeroed.
    for (int c = 0; c < 3; c++)
      for (int j = 0; j < 3; j++) lw[c][j] = 8'($urandom_range(0, 255));
    act_in1 = 8'd77; act_in2 = 8'd13; act_in3 = 8'd200;
    psum_in1 = 8'd5; psum_in2 = 8'd6; psum_in3 = 8'd7;
    load_weights(1'b1);
    {act_in1, act_in2, act_in3} = '0;
    {psum_in1, psum_in2, psum_in3} = '0;
    check_zero("clrload");
    rand_vectors(5);
    run_stream("clrload");

    // Overflow: all weights and activations 16.
    for (int c = 0; c < 3; c++)
      for (int j = 0; j < 3; j++) lw[c][j] = 8'd16;
    load_weights(1'b0);
    nv = 3;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 3; i++) begin
        a_v[k][i] = 8'd16;
        p_v[k][i] = 8'd0;
      end
    run_stream("ovf");
    chk("ovf out1", cap[5][0], OvfExp);
    chk("ovf out2", cap[5][1], OvfExp);
    chk("ovf out3", cap[5][2], OvfExp);

    // Asynchronous reset mid-stream; restarts with zero weights.
    for (int c = 0; c < 3; c++)
      for (int j = 0; j < 3; j++) lw[c][j] = 8'($urandom_range(1, 255));
    load_weights(1'b0);
    act_in1 = 8'd9; act_in2 = 8'd8; act_in3 = 8'd7;
    psum_in1 = 8'd3; psum_in2 = 8'd4; psum_in3 = 8'd5;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_zero("rst async");
    {act_in1, act_in2, act_in3} = '0;
    {psum_in1, psum_in2, psum_in3} = '0;
    #2;
    rst = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int j = 0; j < 3; j++) wm[r][j] = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst idle");
    rand_vectors(5);
    run_stream("postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
